// File: rtl/multdiv_pkg.sv
// Shared encodings for the Execute-stage multiply/divide unit; the controller
// and hazard unit import the same op codes, state names and default width.
package multdiv_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdState_t;

endpackage

// File: rtl/multdiv_if.sv
// Issue / mt-write / HI-LO read bundle between the controller side and the
// multiply/divide unit.
interface multdiv_if import multdiv_pkg::*; #(
   parameter int WIDTH = MD_WIDTH
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             hiwe;
   logic             lowe;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srca, srcb, hiwe, lowe, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, srca, srcb, hiwe, lowe, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/multdiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO: one bit per cycle on
// operand magnitudes, with sign correction applied in a single FIX cycle.
module multdiv_unit import multdiv_pkg::*; #(
   parameter int WIDTH = MD_WIDTH
) (
   input logic      clk,
   input logic      reset,
   multdiv_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   mdState_t stateReg, stateNext;

   logic [CW-1:0]      cntReg;
   logic               mulReg;
   logic               negResReg;
   logic               negRemReg;
   logic [WIDTH-1:0]   aMagReg;
   logic [WIDTH-1:0]   bMagReg;
   logic [WIDTH-1:0]   srcaReg;
   logic [2*WIDTH-1:0] accReg;
   logic [2*WIDTH-1:0] accNext;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic               doneReg;

   logic               signA, signB;
   logic [WIDTH:0]     addSum;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   resHi, resLo;

   function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) stateReg <= IDLE;
      else        stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (bus.start) stateNext = RUN;
         RUN:     if (cntReg == '0) stateNext = FIX;
         FIX:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Sign flags only matter for the signed ops (op[0] == 0).
   assign signA = ~bus.op[0] & bus.srca[WIDTH-1];
   assign signB = ~bus.op[0] & bus.srcb[WIDTH-1];

   // Shared accumulator: multiply keeps {partial product, multiplier},
   // divide keeps {partial remainder, dividend/quotient}.
   always_comb begin
      addSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]} + {1'b0, (accReg[0] ? aMagReg : '0)};
      trial   = accReg[2*WIDTH-1:WIDTH-1] - {1'b0, bMagReg};
      accNext = accReg;
      if (mulReg)        accNext = {addSum, accReg[WIDTH-1:1]};
      else if (trial[WIDTH]) accNext = {accReg[2*WIDTH-2:0], 1'b0};
      else               accNext = {trial[WIDTH-1:0], accReg[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      prodFix = negResReg ? (~accReg + (2*WIDTH)'(1)) : accReg;
      resHi   = prodFix[2*WIDTH-1:WIDTH];
      resLo   = prodFix[WIDTH-1:0];
      if (!mulReg) begin
         if (bMagReg == '0) begin
            resHi = srcaReg;
            resLo = '1;
         end else begin
            resHi = negRemReg ? negW(accReg[2*WIDTH-1:WIDTH]) : accReg[2*WIDTH-1:WIDTH];
            resLo = negResReg ? negW(accReg[WIDTH-1:0]) : accReg[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cntReg    <= '0;
         mulReg    <= 1'b0;
         negResReg <= 1'b0;
         negRemReg <= 1'b0;
         aMagReg   <= '0;
         bMagReg   <= '0;
         srcaReg   <= '0;
         accReg    <= '0;
         hiReg     <= '0;
         loReg     <= '0;
         doneReg   <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (bus.hiwe) hiReg <= bus.wdata;
               if (bus.lowe) loReg <= bus.wdata;
               if (bus.start) begin
                  mulReg    <= ~bus.op[1];
                  negResReg <= signA ^ signB;
                  negRemReg <= signA;
                  aMagReg   <= signA ? negW(bus.srca) : bus.srca;
                  bMagReg   <= signB ? negW(bus.srcb) : bus.srcb;
                  srcaReg   <= bus.srca;
                  accReg    <= {{WIDTH{1'b0}},
                                (bus.op[1] ? (signA ? negW(bus.srca) : bus.srca)
                                           : (signB ? negW(bus.srcb) : bus.srcb))};
                  cntReg    <= CW'(WIDTH - 1);
               end
            end
            RUN: begin
               accReg <= accNext;
               cntReg <= cntReg - CW'(1);
            end
            FIX: begin
               hiReg   <= resHi;
               loReg   <= resLo;
               doneReg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (stateReg != IDLE);
   assign bus.done = doneReg;
   assign bus.hi   = hiReg;
   assign bus.lo   = loReg;

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomised and directed checks of multdiv_unit against a plain-arithmetic
// HI/LO model, with a done-driven scoreboard monitor.
module tb_multdiv_unit;
   import multdiv_pkg::*;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multdiv_if #(.WIDTH(W)) bus ();

   multdiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int doneSeen = 0;
   int doneExpected = 0;
   logic [63:0] expQ[$];
   logic [31:0] modelHi, modelLo;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: {hi, lo} straight from integer arithmetic on the operands.
   function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, p;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      res = '0;
      case (op)
         MD_MULT:  begin q = sa * sb; res = q; end
         MD_MULTU: begin p = ua * ub; res = p; end
         MD_DIV: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               p = ua / ub;
               q = longint'(ua % ub);
               res = {q[31:0], p[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard monitor: every done pulse consumes one expected result.
   always @(negedge clk) begin
      if (reset && bus.done) begin
         doneSeen++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected done: got hi=%h lo=%h, expected no completion", bus.hi, bus.lo);
         end else begin
            logic [63:0] e;
            e = expQ.pop_front();
            check("result", {bus.hi, bus.lo}, e);
            $display("txn %0d: hi=%h lo=%h", doneSeen, bus.hi, bus.lo);
         end
      end
   end

   task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expRes, input bit withMt, input logic [31:0] mtData,
                       input int injectAt);
      int n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.srca  = a;
      bus.srcb  = b;
      bus.hiwe  = withMt;
      bus.wdata = mtData;
      expQ.push_back(expRes);
      doneExpected++;
      @(negedge clk);
      bus.start = 1'b0;
      bus.hiwe  = 1'b0;
      if (withMt) begin
         modelHi = mtData;
         check("mthi with start", {32'h0, bus.hi}, {32'h0, mtData});
      end
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         if (injectAt != 0 && n == injectAt) begin
            bus.start = 1'b1;
            bus.op    = 2'($urandom_range(0, 3));
            bus.srca  = $urandom;
            bus.srcb  = $urandom;
            bus.hiwe  = 1'b1;
            bus.lowe  = 1'b1;
            bus.wdata = 32'h0000_1234;
         end else if (injectAt != 0 && n == injectAt + 1) begin
            bus.start = 1'b0;
            bus.hiwe  = 1'b0;
            bus.lowe  = 1'b0;
            check("mt while busy", {bus.hi, bus.lo}, {modelHi, modelLo});
         end
         @(negedge clk);
      end
      check("busy cycles", 64'(n), 64'(LAT));
      modelHi = expRes[63:32];
      modelLo = expRes[31:0];
   endtask

   task automatic mtWrite(input bit hw, input bit lw, input logic [31:0] data);
      @(negedge clk);
      bus.hiwe  = hw;
      bus.lowe  = lw;
      bus.wdata = data;
      @(negedge clk);
      bus.hiwe = 1'b0;
      bus.lowe = 1'b0;
      if (hw) modelHi = data;
      if (lw) modelLo = data;
      check("mt write", {bus.hi, bus.lo}, {modelHi, modelLo});
      $display("mt: hiwe=%0b lowe=%0b data=%h", hw, lw, data);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.srca  = '0;
      bus.srcb  = '0;
      bus.hiwe  = 1'b0;
      bus.lowe  = 1'b0;
      bus.wdata = '0;
      reset     = 1'b0;
      modelHi   = '0;
      modelLo   = '0;
      repeat (3) @(negedge clk);
      check("reset busy", {63'h0, bus.busy}, 64'h0);
      check("reset done", {63'h0, bus.done}, 64'h0);
      check("reset hilo", {bus.hi, bus.lo}, 64'h0);
      reset = 1'b1;

      doOp(MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, '0, 0);
      doOp(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, '0, 0);
      doOp(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, '0, 0);
      doOp(MD_DIVU,  32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b0, '0, 0);
      doOp(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, '0, 0);
      doOp(MD_DIV,   32'h8000_0005, 32'h0000_0000, 64'h8000_0005_FFFF_FFFF, 1'b0, '0, 0);
      // Second start plus mt writes while busy must be ignored.
      doOp(MD_MULT,  32'h0001_0003, 32'hFFFF_0010, refModel(MD_MULT, 32'h0001_0003, 32'hFFFF_0010), 1'b0, '0, 5);
      mtWrite(1'b0, 1'b1, 32'h0000_ABCD);
      mtWrite(1'b1, 1'b0, 32'h0000_5555);
      doOp(MD_MULTU, 32'h0000_1000, 32'h0000_0010, 64'h0000_0000_0001_0000, 1'b1, 32'h0000_0777, 0);

      // Reset in the middle of a divu discards the result and clears HI/LO.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = MD_DIVU;
      bus.srca  = 32'h1234_5678;
      bus.srcb  = 32'h0000_0013;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midop reset busy", {63'h0, bus.busy}, 64'h0);
      check("midop reset done", {63'h0, bus.done}, 64'h0);
      check("midop reset hilo", {bus.hi, bus.lo}, 64'h0);
      reset   = 1'b1;
      modelHi = '0;
      modelLo = '0;
      repeat (40) @(negedge clk);
      check("idle after reset", {63'h0, bus.busy}, 64'h0);
      doOp(MD_DIVU, 32'h1234_5678, 32'h0000_0013, refModel(MD_DIVU, 32'h1234_5678, 32'h0000_0013), 1'b0, '0, 0);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pickOperand();
         b  = pickOperand();
         doOp(op, a, b, refModel(op, a, b), 1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
      end

      repeat (3) @(negedge clk);
      check("done count", 64'(doneSeen), 64'(doneExpected));
      check("queue drained", 64'(expQ.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
